// File: rtl/scope_pkg.sv
// Shared types and constants for the scope capture/dump path.
package scope_pkg;

  localparam int unsigned DUMP_DEPTH = 512;
  localparam int unsigned DUMP_AW    = 9;
  localparam int unsigned DUMP_DW    = 8;
  localparam int unsigned DUMP_NCH   = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_CAP = 3'd1,
    ST_READ     = 3'd2,
    ST_LATCH    = 3'd3,
    ST_SEND     = 3'd4,
    ST_WAIT_TX  = 3'd5,
    ST_DONE     = 3'd6
  } dump_state_t;

  typedef enum logic [1:0] {
    CH1    = 2'd0,
    CH2    = 2'd1,
    CH3    = 2'd2,
    CH_BAD = 2'd3
  } chan_t;

  // One-hot RAM enable for a channel; the illegal code enables nothing.
  function automatic logic [DUMP_NCH-1:0] chan_onehot(input chan_t c);
    logic [DUMP_NCH-1:0] oh;
    case (c)
      CH1:     oh = 3'b001;
      CH2:     oh = 3'b010;
      CH3:     oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/circ_addr_cnt.sv
// Circular read-address counter: loadable, increments with modulo-DEPTH wrap.
module circ_addr_cnt #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [AW-1:0] load_val_i,
  input  logic          inc_i,
  output logic [AW-1:0] addr_o
);

  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_val_i;
    end else if (inc_i) begin
      addr_d = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/dump_ctrl.sv
// Dump sequencer: streams one capture channel, oldest sample first, to the UART TX.
module dump_ctrl
  import scope_pkg::*;
#(
  parameter int unsigned DEPTH = DUMP_DEPTH,
  parameter int unsigned AW    = DUMP_AW,
  parameter int unsigned DW    = DUMP_DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_start,
  input  logic [1:0]        dump_chan,
  input  logic [AW-1:0]     trace_end,
  input  logic              capture_busy,
  input  logic [3*DW-1:0]   ch_rdata,
  output logic [AW-1:0]     ram_addr,
  output logic [2:0]        ram_en,
  output logic [DW-1:0]     tx_data,
  output logic              trmt,
  input  logic              tx_done,
  output logic              dump_busy,
  output logic              dump_done,
  output logic              cmd_err
);

  localparam int unsigned CW = AW + 1;

  dump_state_t   state_q, state_d;
  chan_t         chan_q, chan_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [2:0]    ram_en_q, ram_en_d;
  logic          trmt_q, trmt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          addr_load_c;
  logic          addr_inc_c;
  logic [AW-1:0] addr_start_c;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] rdata_sel_c;

  // Oldest sample sits just after the newest one.
  assign addr_start_c = (trace_end == AW'(DEPTH - 1)) ? '0 : trace_end + AW'(1);

  circ_addr_cnt #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (addr_load_c),
    .load_val_i (addr_start_c),
    .inc_i      (addr_inc_c),
    .addr_o     (addr_c)
  );

  always_comb begin
    case (chan_q)
      CH2:     rdata_sel_c = ch_rdata[DW +: DW];
      CH3:     rdata_sel_c = ch_rdata[2*DW +: DW];
      default: rdata_sel_c = ch_rdata[0 +: DW];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    err_d       = 1'b0;
    addr_load_c = 1'b0;
    addr_inc_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dump_start) begin
          if (chan_t'(dump_chan) == CH_BAD) begin
            err_d = 1'b1;
          end else begin
            chan_d      = chan_t'(dump_chan);
            cnt_d       = '0;
            addr_load_c = 1'b1;
            state_d     = ST_WAIT_CAP;
          end
        end
      end
      ST_WAIT_CAP: begin
        if (!capture_busy) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        tx_data_d = rdata_sel_c;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        addr_inc_c = 1'b1;
        cnt_d      = cnt_q + CW'(1);
        state_d    = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (tx_done) begin
          state_d = (cnt_q == CW'(DEPTH)) ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered outputs are decoded from the state being entered.
    ram_en_d   = (state_d == ST_READ) ? chan_onehot(chan_q) : 3'b000;
    ram_addr_d = (state_d == ST_READ) ? addr_c : ram_addr_q;
    trmt_d     = (state_d == ST_SEND);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      chan_q     <= CH1;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      ram_addr_q <= '0;
      ram_en_q   <= '0;
      trmt_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      ram_addr_q <= ram_addr_d;
      ram_en_q   <= ram_en_d;
      trmt_q     <= trmt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_en    = ram_en_q;
  assign tx_data   = tx_data_q;
  assign trmt      = trmt_q;
  assign dump_busy = busy_q;
  assign dump_done = done_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_dump_ctrl.sv
// Randomized bench for dump_ctrl with a RAM/UART environment and a sequence-level model.
module tb_dump_ctrl;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dump_start;
  logic [1:0]  dump_chan;
  logic [8:0]  trace_end;
  logic        capture_busy;
  logic [23:0] ch_rdata;
  logic [8:0]  ram_addr;
  logic [2:0]  ram_en;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        dump_busy;
  logic        dump_done;
  logic        cmd_err;

  int tests = 0;
  int fails = 0;

  dump_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dump_start   (dump_start),
    .dump_chan    (dump_chan),
    .trace_end    (trace_end),
    .capture_busy (capture_busy),
    .ch_rdata     (ch_rdata),
    .ram_addr     (ram_addr),
    .ram_en       (ram_en),
    .tx_data      (tx_data),
    .trmt         (trmt),
    .tx_done      (tx_done),
    .dump_busy    (dump_busy),
    .dump_done    (dump_done),
    .cmd_err      (cmd_err)
  );

  always #5 clk = ~clk;

  // Capture RAMs: one-cycle read latency.
  logic [7:0] mem [3][DEPTH];
  initial ch_rdata = '0;
  always @(posedge clk) begin
    if (ram_en[0]) ch_rdata[7:0]   <= mem[0][ram_addr];
    if (ram_en[1]) ch_rdata[15:8]  <= mem[1][ram_addr];
    if (ram_en[2]) ch_rdata[23:16] <= mem[2][ram_addr];
  end

  // UART: tx_done pulses tx_delay cycles after each trmt.
  int   tx_delay = 1;
  int   pend = 0;
  logic uart_pulse = 1'b0;
  logic stray_tx = 1'b0;
  always @(posedge clk) begin
    #1;
    uart_pulse = 1'b0;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) uart_pulse = 1'b1;
      end
      if (trmt) pend = tx_delay;
    end
  end
  assign tx_done = uart_pulse | stray_tx;

  // Output monitor.
  logic [8:0] mon_addr[$];
  logic [2:0] mon_en[$];
  logic [7:0] mon_byte[$];
  logic [7:0] held;
  bit         in_wait = 1'b0;
  int         stab_err = 0, done_cnt = 0, err_cnt = 0, busy_cycles = 0;
  always @(negedge clk) begin
    if (ram_en != 3'b000) begin
      mon_addr.push_back(ram_addr);
      mon_en.push_back(ram_en);
    end
    if (trmt) begin
      mon_byte.push_back(tx_data);
      held    = tx_data;
      in_wait = 1'b1;
    end else if (in_wait) begin
      if (tx_data !== held) stab_err++;
      if (tx_done) in_wait = 1'b0;
    end
    if (dump_done) done_cnt++;
    if (cmd_err) err_cnt++;
    if (dump_busy) busy_cycles++;
  end

  // Reference model: DEPTH samples oldest first, starting just after trace_end.
  logic [8:0] exp_addr[$];
  logic [7:0] exp_byte[$];
  function automatic void build_model(input int ch, input int te);
    exp_addr.delete();
    exp_byte.delete();
    for (int i = 0; i < DEPTH; i++) begin
      int a;
      a = (te + 1 + i) % DEPTH;
      exp_addr.push_back(9'(a));
      exp_byte.push_back(mem[ch][a]);
    end
  endfunction

  task automatic clear_mon();
    mon_addr.delete();
    mon_en.delete();
    mon_byte.delete();
    stab_err = 0; done_cnt = 0; err_cnt = 0; busy_cycles = 0;
    in_wait = 1'b0;
  endtask

  task automatic start_dump(input logic [1:0] ch, input logic [8:0] te);
    @(negedge clk);
    dump_chan  = ch;
    trace_end  = te;
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    trace_end  = 9'($urandom);
  endtask

  // mode bit0: toggle capture_busy; bit1: random dump_start/chan/trace_end.
  task automatic wait_done(input int budget, input int mode, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (dump_done) begin
        ok = 1'b1;
        break;
      end
      if (mode[0]) capture_busy = 1'($urandom);
      if (mode[1]) begin
        dump_start = ($urandom_range(0, 7) == 0);
        dump_chan  = 2'($urandom);
        trace_end  = 9'($urandom);
      end
    end
    dump_start   = 1'b0;
    capture_busy = 1'b0;
    @(negedge clk);
  endtask

  task automatic fill_mem();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < DEPTH; i++) mem[k][i] = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({ram_addr, ram_en, tx_data} !== 20'h0) begin
      fails++;
      $display("FAIL reset_data: addr=%0h en=%b tx=%0h, required all 0", ram_addr, ram_en, tx_data);
    end
    tests++;
    if ({trmt, dump_busy, dump_done, cmd_err} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctrl: trmt=%b busy=%b done=%b err=%b, required 0", trmt, dump_busy, dump_done, cmd_err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap_chan1();
    bit ok;
    int ae, be, ee;
    for (int i = 0; i < DEPTH; i++) mem[1][i] = 8'(i);
    clear_mon();
    tx_delay = 1;
    build_model(1, 511);
    start_dump(2'd1, 9'd511);
    wait_done(20000, 0, ok);
    ae = 0; be = 0; ee = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i >= mon_addr.size() || mon_addr[i] !== 9'(i)) ae++;
      if (i >= mon_en.size() || mon_en[i] !== 3'b010) ee++;
      if (i >= mon_byte.size() || mon_byte[i] !== exp_byte[i]) be++;
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL wrap_timeout: dump_done not seen, required within budget"); end
    tests++;
    if (ae != 0 || mon_addr.size() != DEPTH) begin
      fails++; $display("FAIL wrap_addr: %0d bad of %0d reads, required 0 bad of 512", ae, mon_addr.size());
    end
    tests++;
    if (ee != 0) begin fails++; $display("FAIL wrap_en: %0d reads not 010, required 0", ee); end
    tests++;
    if (be != 0 || mon_byte.size() != DEPTH) begin
      fails++; $display("FAIL wrap_bytes: %0d bad of %0d trmt, required 0 bad of 512", be, mon_byte.size());
    end
    tests++;
    if (done_cnt != 1 || dump_busy !== 1'b0) begin
      fails++; $display("FAIL wrap_done: done=%0d busy=%b, required 1 and 0", done_cnt, dump_busy);
    end
  endtask

  task automatic test_slow_uart_chan0();
    bit ok;
    int ae, be;
    fill_mem();
    clear_mon();
    tx_delay = 5;
    build_model(0, 100);
    start_dump(2'd0, 9'd100);
    wait_done(20000, 0, ok);
    ae = 0; be = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i >= mon_addr.size() || mon_addr[i] !== exp_addr[i]) ae++;
      if (i >= mon_byte.size() || mon_byte[i] !== exp_byte[i]) be++;
    end
    tests++;
    if (!ok || mon_addr.size() != DEPTH) begin
      fails++; $display("FAIL slow_count: ok=%0d reads=%0d, required 1 and 512", ok, mon_addr.size());
    end
    tests++;
    if (mon_addr.size() < 1 || mon_addr[0] !== 9'd101 || mon_addr[mon_addr.size()-1] !== 9'd100) begin
      fails++; $display("FAIL slow_ends: first/last addr wrong, required 101 and 100");
    end
    tests++;
    if (ae != 0) begin fails++; $display("FAIL slow_addr: %0d bad addresses, required 0", ae); end
    tests++;
    if (be != 0) begin fails++; $display("FAIL slow_bytes: %0d bad bytes, required 0", be); end
    tests++;
    if (stab_err != 0) begin fails++; $display("FAIL slow_stable: %0d tx_data changes in wait, required 0", stab_err); end
  endtask

  task automatic test_bad_chan();
    clear_mon();
    start_dump(2'd3, 9'($urandom));
    repeat (6) @(negedge clk);
    tests++;
    if (err_cnt != 1) begin fails++; $display("FAIL bad_err: cmd_err cycles=%0d, required 1", err_cnt); end
    tests++;
    if (busy_cycles != 0 || mon_addr.size() != 0) begin
      fails++; $display("FAIL bad_idle: busy=%0d reads=%0d, required 0 and 0", busy_cycles, mon_addr.size());
    end
  endtask

  task automatic test_capture_busy();
    bit ok;
    int ae, be, te;
    fill_mem();
    clear_mon();
    tx_delay = $urandom_range(1, 3);
    te = $urandom_range(0, DEPTH - 1);
    build_model(2, te);
    capture_busy = 1'b1;
    start_dump(2'd2, 9'(te));
    repeat (20) @(negedge clk);
    tests++;
    if (mon_addr.size() != 0 || dump_busy !== 1'b1) begin
      fails++; $display("FAIL cap_hold: reads=%0d busy=%b, required 0 and 1", mon_addr.size(), dump_busy);
    end
    capture_busy = 1'b0;
    wait_done(20000, 1, ok);
    ae = 0; be = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i >= mon_addr.size() || mon_addr[i] !== exp_addr[i] || mon_en[i] !== 3'b100) ae++;
      if (i >= mon_byte.size() || mon_byte[i] !== exp_byte[i]) be++;
    end
    tests++;
    if (!ok || ae != 0 || be != 0) begin
      fails++; $display("FAIL cap_toggle: ok=%0d bad_addr=%0d bad_byte=%0d, required 1 0 0", ok, ae, be);
    end
  endtask

  task automatic test_ignore();
    bit ok;
    int be, ch, te;
    clear_mon();
    repeat (2) @(negedge clk);
    stray_tx = 1'b1;
    repeat (3) @(negedge clk);
    stray_tx = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy_cycles != 0 || mon_byte.size() != 0) begin
      fails++; $display("FAIL stray_tx: busy=%0d trmt=%0d, required 0 and 0", busy_cycles, mon_byte.size());
    end
    fill_mem();
    clear_mon();
    tx_delay = $urandom_range(1, 4);
    ch = $urandom_range(0, 2);
    te = $urandom_range(0, DEPTH - 1);
    build_model(ch, te);
    start_dump(2'(ch), 9'(te));
    wait_done(30000, 3, ok);
    be = 0;
    for (int i = 0; i < DEPTH; i++)
      if (i >= mon_byte.size() || mon_byte[i] !== exp_byte[i]) be++;
    tests++;
    if (!ok || mon_byte.size() != DEPTH || be != 0) begin
      fails++; $display("FAIL ignore_bytes: ok=%0d count=%0d bad=%0d, required 1 512 0", ok, mon_byte.size(), be);
    end
    tests++;
    if (err_cnt != 0 || done_cnt != 1) begin
      fails++; $display("FAIL ignore_pulses: err=%0d done=%0d, required 0 and 1", err_cnt, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, got;
    int be, te, dc;
    fill_mem();
    clear_mon();
    tx_delay = 2;
    start_dump(2'($urandom_range(0, 2)), 9'($urandom));
    got = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (mon_byte.size() >= 10) begin got = 1'b1; break; end
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (!got || {ram_addr, ram_en, tx_data, trmt, dump_busy, dump_done, cmd_err} !== 24'h0) begin
      fails++;
      $display("FAIL midreset_out: got10=%0d addr=%0h en=%b tx=%0h trmt=%b busy=%b, required all 0",
               got, ram_addr, ram_en, tx_data, trmt, dump_busy);
    end
    rst_n = 1'b1;
    dc = done_cnt;
    repeat (30) @(negedge clk);
    tests++;
    if (done_cnt != dc || dump_busy !== 1'b0) begin
      fails++; $display("FAIL midreset_done: done pulses=%0d busy=%b, required 0 and 0", done_cnt - dc, dump_busy);
    end
    clear_mon();
    te = $urandom_range(0, DEPTH - 1);
    build_model(2, te);
    start_dump(2'd2, 9'(te));
    wait_done(20000, 0, ok);
    be = 0;
    for (int i = 0; i < DEPTH; i++)
      if (i >= mon_byte.size() || mon_byte[i] !== exp_byte[i] || mon_addr[i] !== exp_addr[i]) be++;
    tests++;
    if (!ok || be != 0 || done_cnt != 1) begin
      fails++; $display("FAIL midreset_next: ok=%0d bad=%0d done=%0d, required 1 0 1", ok, be, done_cnt);
    end
  endtask

  initial begin
    dump_start   = 1'b0;
    dump_chan    = 2'd0;
    trace_end    = '0;
    capture_busy = 1'b0;
    fill_mem();
    test_reset();
    test_wrap_chan1();
    test_slow_uart_chan0();
    test_bad_chan();
    test_capture_busy();
    test_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
